ws2812b_segment_driver: RTL and testbench

Parametrised WS2812B serial driver that streams one frame of up to `max_count` pixels, each pixel coloured from a prioritised list of `SEG_N` colour segments, followed by a latch reset gap. It sits between the meter/colour configuration logic and the LED strip output pin. It generalises the original three-colour meter controller in several ways: configurable segment count and bit timing, shadowed configuration per frame, and a status/handshake output.

---
 rtl/ws2812b_segment_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_ws2812b_segment_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_segment_driver.sv
// WS2812B frame streamer.
// Each frame is a latch gap (dout low) followed by max_count pixels of 24 GRB
// bits, MSB first. Pixel colours come from a prioritised list of SEG_N
// segments, resolved from shadow copies taken at the end of the latch gap.
module ws2812b_segment_driver #(
    parameter int SEG_N     = 3,
    parameter int CNT_W     = 16,
    parameter int T0H_CYC   = 40,
    parameter int T1H_CYC   = 80,
    parameter int BIT_CYC   = 125,
    parameter int RESET_CYC = 30000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   is_enable,
    input  logic [SEG_N*24-1:0]    colors,
    input  logic [SEG_N*CNT_W-1:0] seg_counts,
    input  logic [CNT_W-1:0]       max_count,
    output logic                   dout,
    output logic                   busy,
    output logic                   frame_done
);
    // Prefix sums are wide enough that SEG_N full counts can never wrap.
    localparam int PW = CNT_W + $clog2(SEG_N) + 1;
    // Segment index needs one extra code (SEG_N) meaning "past the last segment".
    localparam int KW = $clog2(SEG_N + 1);
    localparam int BW = $clog2(BIT_CYC);
    localparam int RW = $clog2(RESET_CYC);

    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);
    localparam logic [BW-1:0] T0H      = BW'(T0H_CYC);
    localparam logic [BW-1:0] T1H      = BW'(T1H_CYC);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYC - 1);
    localparam logic [KW-1:0] K_NONE   = KW'(SEG_N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Frame sequencing counters
    logic [RW-1:0]    rst_cnt;
    logic [BW-1:0]    bit_cyc;
    logic [BW-1:0]    nxt_cyc;
    logic [4:0]       bit_idx;
    logic [CNT_W-1:0] pix;
    logic [23:0]      pix_color;

    // Shadow configuration, frozen for the whole frame
    logic [23:0]      sh_col [SEG_N];
    logic [CNT_W-1:0] sh_cnt [SEG_N];
    logic [CNT_W-1:0] sh_max;

    // Incremental colour resolver: cur_k is the segment holding pixel pix+1
    // once it settles, cur_end is the prefix sum through cur_k.
    logic [KW-1:0]    cur_k;
    logic [PW-1:0]    cur_end;
    logic [PW-1:0]    target;
    logic             res_step;
    logic [23:0]      next_color;
    logic [CNT_W-1:0] step_cnt;
    logic [23:0]      first_col;

    logic             rst_last;
    logic             bit_wrap;
    logic             frame_end;
    logic             nxt_bit;
    logic             dout_d;

    assign rst_last  = (rst_cnt == RST_LAST);
    assign bit_wrap  = (bit_cyc == BIT_LAST);
    assign frame_end = (state == S_DATA) && bit_wrap && (bit_idx == 5'd0) &&
                       (pix == sh_max - CNT_W'(1));
    assign target    = PW'(pix) + PW'(1);
    assign res_step  = (cur_k != K_NONE) && (target >= cur_end);

    // Pixel 0 is simply the first segment with a non-zero count; evaluated on
    // the live inputs so it is ready on the same edge the shadows are taken.
    always_comb begin
        first_col = '0;
        for (int k = SEG_N - 1; k >= 0; k--) begin
            if (seg_counts[k*CNT_W +: CNT_W] != '0)
                first_col = colors[k*24 +: 24];
        end
    end

    // Resolver lookups: colour of the current segment and count of the next one.
    always_comb begin
        next_color = '0;
        step_cnt   = '0;
        for (int k = 0; k < SEG_N; k++) begin
            if (cur_k == KW'(k))
                next_color = sh_col[k];
            if (k > 0 && cur_k == KW'(k - 1))
                step_cnt = sh_cnt[k];
        end
    end

    // State register; async reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (is_enable) state_next = S_RESET;
            end
            S_RESET: begin
                if (rst_last) begin
                    if (!is_enable)            state_next = S_IDLE;
                    else if (max_count == '0)  state_next = S_RESET;
                    else                       state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_end) state_next = S_RESET;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Position of the next cycle within its bit, and the value of that bit.
    always_comb begin
        nxt_cyc = '0;
        nxt_bit = 1'b0;
        if (state == S_RESET) begin
            nxt_bit = first_col[23];
        end else if (state == S_DATA) begin
            if (bit_wrap) begin
                nxt_cyc = '0;
                if (bit_idx == 5'd0) nxt_bit = next_color[23];
                else                 nxt_bit = pix_color[bit_idx - 5'd1];
            end else begin
                nxt_cyc = bit_cyc + BW'(1);
                nxt_bit = pix_color[bit_idx];
            end
        end
    end

    // Outputs: status from the current state, line level for the next cycle.
    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = frame_end;
        dout_d     = (state_next == S_DATA) &&
                     (nxt_cyc < (nxt_bit ? T1H : T0H));
    end

    // Registered line driver, cleared immediately on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dout <= 1'b0;
        else          dout <= dout_d;
    end

    // Gap/bit/pixel counters, shadow capture and colour resolver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt   <= '0;
            bit_cyc   <= '0;
            bit_idx   <= '0;
            pix       <= '0;
            pix_color <= '0;
            sh_max    <= '0;
            cur_k     <= '0;
            cur_end   <= '0;
            for (int k = 0; k < SEG_N; k++) begin
                sh_col[k] <= '0;
                sh_cnt[k] <= '0;
            end
        end else begin
            case (state)
                S_RESET: begin
                    if (rst_last) begin
                        rst_cnt   <= '0;
                        sh_max    <= max_count;
                        for (int k = 0; k < SEG_N; k++) begin
                            sh_col[k] <= colors[k*24 +: 24];
                            sh_cnt[k] <= seg_counts[k*CNT_W +: CNT_W];
                        end
                        // Resolver restarts at segment 0; it walks towards
                        // pixel 1 while pixel 0 is on the wire.
                        cur_k     <= '0;
                        cur_end   <= PW'(seg_counts[CNT_W-1:0]);
                        pix_color <= first_col;
                        pix       <= '0;
                        bit_cyc   <= '0;
                        bit_idx   <= 5'd23;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_DATA: begin
                    rst_cnt <= '0;
                    if (res_step) begin
                        cur_k   <= cur_k + KW'(1);
                        cur_end <= cur_end + PW'(step_cnt);
                    end
                    bit_cyc <= nxt_cyc;
                    if (bit_wrap) begin
                        if (bit_idx == 5'd0) begin
                            bit_idx   <= 5'd23;
                            pix       <= pix + CNT_W'(1);
                            pix_color <= next_color;
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                        end
                    end
                end
                default: begin
                    rst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_segment_driver.sv
// Directed bench for ws2812b_segment_driver. Expected pixels are pushed to a
// scoreboard queue when a frame is requested; a line monitor decodes dout
// back into pixels and compares them in order.
module tb_ws2812b_segment_driver;
    localparam int SEG_N   = 3;
    localparam int CNT_W   = 8;
    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int BITC    = 6;
    localparam int RSTC    = 10;
    localparam int PIX_CYC = 24 * BITC;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   is_enable = 1'b0;
    logic [SEG_N*24-1:0]    colors = '0;
    logic [SEG_N*CNT_W-1:0] seg_counts = '0;
    logic [CNT_W-1:0]       max_count = '0;
    logic                   dout;
    logic                   busy;
    logic                   frame_done;

    logic [23:0] col [SEG_N];
    int          cnt [SEG_N];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fd_pulses = 0;
    logic [23:0] sb [$];
    int          hi_len = 0;
    int          nbits = 0;
    logic [23:0] shreg = '0;
    logic [23:0] exp_px;

    ws2812b_segment_driver #(
        .SEG_N(SEG_N), .CNT_W(CNT_W), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .BIT_CYC(BITC), .RESET_CYC(RSTC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .is_enable(is_enable),
        .colors(colors), .seg_counts(seg_counts), .max_count(max_count),
        .dout(dout), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first segment whose running total exceeds the pixel index.
    function automatic logic [23:0] model_pix(input int i);
        int acc = 0;
        for (int k = 0; k < SEG_N; k++) begin
            acc += cnt[k];
            if (i < acc) return col[k];
        end
        return 24'h000000;
    endfunction

    task automatic apply(input int mc);
        for (int k = 0; k < SEG_N; k++) begin
            colors[k*24 +: 24]         = col[k];
            seg_counts[k*CNT_W +: CNT_W] = cnt[k][CNT_W-1:0];
        end
        max_count = mc[CNT_W-1:0];
    endtask

    task automatic push_frame(input int mc);
        for (int i = 0; i < mc; i++) sb.push_back(model_pix(i));
    endtask

    // Raise is_enable from IDLE; dout must first rise on cycle RSTC+1.
    task automatic start_frame(output int ds);
        int c0;
        int n;
        @(negedge clk);
        is_enable = 1'b1;
        c0 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_in_reset", busy, 1);
        end while (!dout && n < 40);
        chk("data_start_cycle", cyc - c0, RSTC + 1);
        ds = cyc;
    endtask

    // Wait out the frame and the trailing gap (is_enable already low).
    task automatic finish_frame(input int mc, input int ds);
        int n;
        int fd;
        n = 0;
        while (!frame_done && n < mc * PIX_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_cycle", cyc - ds, mc * PIX_CYC - 1);
        fd = cyc;
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
        chk("busy_in_gap", busy, 1);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_after_gap", cyc - fd, RSTC + 1);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    // Line monitor: decode each bit by its high time, assemble pixels.
    initial forever begin
        @(negedge clk);
        if (frame_done) fd_pulses++;
        if (!reset_n) begin
            hi_len = 0;
            nbits  = 0;
        end else if (dout) begin
            hi_len++;
        end else if (hi_len > 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                exp_px = sb[0];
                chk("bit_high_len", hi_len, exp_px[23 - nbits] ? T1H : T0H);
                shreg = {shreg[22:0], (hi_len == T1H)};
                nbits++;
                if (nbits == 24) begin
                    chk("pixel", shreg, exp_px);
                    void'(sb.pop_front());
                    nbits = 0;
                end
            end
            hi_len = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int ds;
        int n;
        int fd0;
        logic [11:0] trace;

        // Reset state
        col[0] = 24'hFF0000; col[1] = 24'h00FF00; col[2] = 24'h0000FF;
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1;
        apply(5);
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_dout", dout, 0);

        // Basic frame: FF0000, FF0000, 00FF00, 0000FF, 000000
        push_frame(5);
        start_frame(ds);
        is_enable = 1'b0;
        finish_frame(5, ds);

        // Zero-count segments are skipped
        cnt[0] = 0; cnt[1] = 3; cnt[2] = 0;
        apply(2);
        push_frame(2);
        start_frame(ds);
        is_enable = 1'b0;
        finish_frame(2, ds);

        // Counts exceed max_count: everything from segment 0
        cnt[0] = 4; cnt[1] = 4; cnt[2] = 4;
        apply(3);
        push_frame(3);
        start_frame(ds);
        is_enable = 1'b0;
        finish_frame(3, ds);

        // Mid-frame changes are ignored until the next frame
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1;
        apply(5);
        push_frame(5);
        start_frame(ds);
        repeat (PIX_CYC + PIX_CYC / 2) @(negedge clk);
        is_enable = 1'b0;
        col[0] = 24'h123456; col[1] = 24'hA5C3E1; col[2] = 24'h0F0F0F;
        apply(5);
        finish_frame(5, ds);
        push_frame(5);
        start_frame(ds);
        is_enable = 1'b0;
        finish_frame(5, ds);

        // max_count = 0: gap repeats, nothing sent, no frame_done
        apply(0);
        fd0 = fd_pulses;
        @(negedge clk);
        is_enable = 1'b1;
        repeat (4 * RSTC + 5) begin
            @(negedge clk);
            chk("zero_dout", dout, 0);
            chk("zero_busy", busy, 1);
            chk("zero_frame_done", frame_done, 0);
        end
        chk("zero_pulse_count", fd_pulses - fd0, 0);
        is_enable = 1'b0;
        n = 0;
        while (busy && n < 2 * RSTC) begin
            @(negedge clk);
            n++;
        end
        chk("zero_to_idle", busy, 0);

        // Bit timing: 1-bit then 0-bits
        col[0] = 24'h800000;
        cnt[0] = 1; cnt[1] = 0; cnt[2] = 0;
        apply(1);
        push_frame(1);
        start_frame(ds);
        trace[11] = dout;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            trace[i] = dout;
        end
        chk("bit_trace", trace, 12'b1111_0011_0000);
        is_enable = 1'b0;
        finish_frame(1, ds);

        // Asynchronous reset in the middle of DATA
        col[0] = 24'hFF0000; col[1] = 24'h00FF00; col[2] = 24'h0000FF;
        cnt[0] = 2; cnt[1] = 1; cnt[2] = 1;
        apply(5);
        push_frame(5);
        start_frame(ds);
        is_enable = 1'b0;
        repeat (200) @(negedge clk);
        n = 0;
        while (!dout && n < 2 * BITC) begin
            @(negedge clk);
            n++;
        end
        chk("async_pre_dout", dout, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_dout", dout, 0);
        chk("async_busy", busy, 0);
        chk("async_frame_done", frame_done, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("async_idle", busy, 0);
        push_frame(5);
        start_frame(ds);
        is_enable = 1'b0;
        finish_frame(5, ds);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
